// File: rtl/ddr3_mcb_arb.sv
// ddr3_mcb_arb: round-robin read/write command-bus arbiter with postponable DDR3 refresh.
// Refreshes are owed per tREFI tick and issued when the bus is idle, or forced once MAX_PEND are owed.
module ddr3_mcb_arb #(
  parameter int TREFI    = 6240,
  parameter int TRFC     = 208,
  parameter int MAX_PEND = 8
) (
  input  logic       ddr3_mcb_clk,
  input  logic       ddr3_mcb_rst_n,
  input  logic       i_ready,
  input  logic       rd_req,
  input  logic       wr_req,
  input  logic       cmd_done,
  output logic       rd_gnt,
  output logic       wr_gnt,
  output logic       ref_cmd,
  output logic       arb_busy,
  output logic [3:0] ref_pend
);
  localparam int RW = $clog2(TREFI + 1);
  localparam int FW = $clog2(TRFC + 1);

  typedef enum logic [2:0] {ARB_OFF, ARB_IDLE, ARB_RD, ARB_WR, ARB_REF, ARB_REFW} arb_state_e;

  arb_state_e    state_q, state_d;
  logic [RW-1:0] refi_q, refi_d;
  logic [FW-1:0] wait_q, wait_d;
  logic [3:0]    ref_pend_q, ref_pend_d;
  logic          last_q, last_d;
  logic          rd_gnt_q, rd_gnt_d, wr_gnt_q, wr_gnt_d;
  logic          ref_cmd_q, ref_cmd_d, arb_busy_q, arb_busy_d;
  logic          tick, dec, sat;

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    wait_d     = wait_q;
    tick       = (state_q != ARB_OFF) && (refi_q == RW'(1));
    dec        = (state_q == ARB_REF);
    sat        = (ref_pend_q == 4'(MAX_PEND));
    refi_d     = (state_q == ARB_OFF) ? (i_ready ? RW'(TREFI) : '0) :
                 (tick ? RW'(TREFI) : refi_q - RW'(1));
    // a tick coinciding with an issued refresh cancels out, even when saturated
    ref_pend_d = (tick && !dec) ? (sat ? ref_pend_q : ref_pend_q + 4'd1) :
                 (dec && !tick) ? ref_pend_q - 4'd1 : ref_pend_q;
    case (state_q)
      ARB_OFF:  if (i_ready) state_d = ARB_IDLE;
      ARB_IDLE: begin
        if (sat) state_d = ARB_REF;
        else if (rd_req && (!wr_req || last_q)) begin
          state_d = ARB_RD;
          last_d  = 1'b0;
        end else if (wr_req) begin
          state_d = ARB_WR;
          last_d  = 1'b1;
        end else if (ref_pend_q != 4'd0) state_d = ARB_REF;
      end
      ARB_RD, ARB_WR: if (cmd_done) state_d = ARB_IDLE;
      ARB_REF: begin
        wait_d  = FW'(TRFC);
        state_d = ARB_REFW;
      end
      ARB_REFW: begin
        if (wait_q == FW'(1)) state_d = ARB_IDLE;
        else wait_d = wait_q - FW'(1);
      end
      default: state_d = ARB_OFF;
    endcase
    rd_gnt_d   = (state_d == ARB_RD);
    wr_gnt_d   = (state_d == ARB_WR);
    ref_cmd_d  = (state_d == ARB_REF);
    arb_busy_d = (state_d != ARB_IDLE);
  end

  always_ff @(posedge ddr3_mcb_clk or negedge ddr3_mcb_rst_n) begin
    if (!ddr3_mcb_rst_n) begin
      state_q    <= ARB_OFF;
      refi_q     <= '0;
      wait_q     <= '0;
      ref_pend_q <= 4'd0;
      last_q     <= 1'b1;
      rd_gnt_q   <= 1'b0;
      wr_gnt_q   <= 1'b0;
      ref_cmd_q  <= 1'b0;
      arb_busy_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      refi_q     <= refi_d;
      wait_q     <= wait_d;
      ref_pend_q <= ref_pend_d;
      last_q     <= last_d;
      rd_gnt_q   <= rd_gnt_d;
      wr_gnt_q   <= wr_gnt_d;
      ref_cmd_q  <= ref_cmd_d;
      arb_busy_q <= arb_busy_d;
    end
  end

  assign rd_gnt   = rd_gnt_q;
  assign wr_gnt   = wr_gnt_q;
  assign ref_cmd  = ref_cmd_q;
  assign arb_busy = arb_busy_q;
  assign ref_pend = ref_pend_q;
endmodule

// File: tb/tb_ddr3_mcb_arb.sv
// tb_ddr3_mcb_arb: scenario tasks for the arbiter with TREFI=16, TRFC=4, MAX_PEND=8.
module tb_ddr3_mcb_arb;
  localparam int TREFI = 16;
  localparam int TRFC = 4;
  localparam int MAXP = 8;

  logic clk = 1'b0;
  logic rst_n, i_ready, rd_req, wr_req, cmd_done;
  logic rd_gnt, wr_gnt, ref_cmd, arb_busy;
  logic [3:0] ref_pend;
  int checks = 0;
  int failures = 0;
  byte exp_q[$];

  ddr3_mcb_arb #(.TREFI(TREFI), .TRFC(TRFC), .MAX_PEND(MAXP)) dut (
    .ddr3_mcb_clk(clk), .ddr3_mcb_rst_n(rst_n), .i_ready(i_ready), .rd_req(rd_req),
    .wr_req(wr_req), .cmd_done(cmd_done), .rd_gnt(rd_gnt), .wr_gnt(wr_gnt),
    .ref_cmd(ref_cmd), .arb_busy(arb_busy), .ref_pend(ref_pend)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    i_ready = 1'b0;
    rd_req = 1'b0;
    wr_req = 1'b0;
    cmd_done = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    i_ready = 1'b0;
    rd_req = 1'b1;
    wr_req = 1'b1;
    cmd_done = 1'b0;
    step();
    step();
    checks++; if (rd_gnt !== 1'b0) begin failures++; $display("FAIL reset_rd_gnt got=%b exp=0", rd_gnt); end
    checks++; if (wr_gnt !== 1'b0) begin failures++; $display("FAIL reset_wr_gnt got=%b exp=0", wr_gnt); end
    checks++; if (ref_cmd !== 1'b0) begin failures++; $display("FAIL reset_ref_cmd got=%b exp=0", ref_cmd); end
    checks++; if (arb_busy !== 1'b1) begin failures++; $display("FAIL reset_busy got=%b exp=1", arb_busy); end
    checks++; if (ref_pend !== 4'd0) begin failures++; $display("FAIL reset_pend got=%0d exp=0", ref_pend); end
  endtask

  task automatic test_off();
    logic ok;
    do_reset();
    rd_req = 1'b1;
    ok = 1'b1;
    repeat (100) begin
      step();
      if (rd_gnt !== 1'b0 || ref_pend !== 4'd0 || arb_busy !== 1'b1) ok = 1'b0;
    end
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL off_hold got=%b exp=1", ok); end
    i_ready = 1'b1;
    step();
    checks++; if (arb_busy !== 1'b0 || rd_gnt !== 1'b0) begin failures++; $display("FAIL off_to_idle busy=%b gnt=%b exp=0/0", arb_busy, rd_gnt); end
    step();
    checks++; if (rd_gnt !== 1'b1) begin failures++; $display("FAIL off_first_gnt got=%b exp=1", rd_gnt); end
    cmd_done = 1'b1;
    step();
    cmd_done = 1'b0;
    rd_req = 1'b0;
    checks++; if (rd_gnt !== 1'b0 || arb_busy !== 1'b0) begin failures++; $display("FAIL off_done gnt=%b busy=%b exp=0/0", rd_gnt, arb_busy); end
  endtask

  task automatic test_rr();
    int budget;
    byte got, exp;
    do_reset();
    i_ready = 1'b1;
    rd_req = 1'b1;
    wr_req = 1'b1;
    for (int i = 0; i < 6; i++) exp_q.push_back((i % 2 == 0) ? "R" : "W");
    budget = 0;
    while (exp_q.size() > 0 && budget < 200) begin
      step();
      budget++;
      if (rd_gnt || wr_gnt) begin
        got = rd_gnt ? "R" : "W";
        exp = exp_q.pop_front();
        checks++;
        if ((rd_gnt && wr_gnt) || got !== exp) begin
          failures++;
          $display("FAIL rr_order got=%c (rd=%b wr=%b) exp=%c", got, rd_gnt, wr_gnt, exp);
        end
        cmd_done = 1'b1;
        step();
        cmd_done = 1'b0;
      end
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL rr_timeout left=%0d exp=0", exp_q.size()); end
    exp_q.delete();
    rd_req = 1'b0;
    wr_req = 1'b0;
  endtask

  task automatic test_refresh();
    int n, w;
    do_reset();
    i_ready = 1'b1;
    n = 0;
    while (ref_cmd !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    checks++; if (n != TREFI + 2) begin failures++; $display("FAIL ref_latency got=%0d exp=%0d", n, TREFI + 2); end
    checks++; if (ref_pend !== 4'd1) begin failures++; $display("FAIL ref_pend_at_cmd got=%0d exp=1", ref_pend); end
    w = 0;
    step();
    while (arb_busy === 1'b1 && ref_cmd === 1'b0 && rd_gnt === 1'b0 && wr_gnt === 1'b0 && w < 50) begin
      w++;
      step();
    end
    checks++; if (w != TRFC) begin failures++; $display("FAIL refw_len got=%0d exp=%0d", w, TRFC); end
    checks++; if (ref_pend !== 4'd0) begin failures++; $display("FAIL ref_pend_after got=%0d exp=0", ref_pend); end
    checks++; if (arb_busy !== 1'b0) begin failures++; $display("FAIL ref_back_idle got=%b exp=0", arb_busy); end
  endtask

  task automatic test_saturate();
    int n;
    logic ok;
    do_reset();
    i_ready = 1'b1;
    rd_req = 1'b1;
    wr_req = 1'b1;
    n = 0;
    while (ref_pend !== 4'(MAXP) && n < 400) begin
      step();
      n++;
    end
    checks++; if (ref_pend !== 4'(MAXP)) begin failures++; $display("FAIL sat_reach got=%0d exp=%0d", ref_pend, MAXP); end
    checks++; if (rd_gnt !== 1'b1) begin failures++; $display("FAIL sat_no_preempt got=%b exp=1", rd_gnt); end
    ok = 1'b1;
    repeat (29) begin
      step();
      if (rd_gnt !== 1'b1 || ref_pend !== 4'(MAXP)) ok = 1'b0;
    end
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL sat_hold got=%b exp=1 pend=%0d", ok, ref_pend); end
    cmd_done = 1'b1;
    step();
    cmd_done = 1'b0;
    checks++; if (arb_busy !== 1'b0 || rd_gnt !== 1'b0) begin failures++; $display("FAIL sat_idle busy=%b gnt=%b exp=0/0", arb_busy, rd_gnt); end
    step();
    checks++; if (ref_cmd !== 1'b1 || rd_gnt !== 1'b0 || wr_gnt !== 1'b0) begin failures++; $display("FAIL sat_ref_first ref=%b rd=%b wr=%b exp=1/0/0", ref_cmd, rd_gnt, wr_gnt); end
    step();
    checks++; if (ref_pend !== 4'(MAXP) || ref_cmd !== 1'b0) begin failures++; $display("FAIL sat_tick_and_ref pend=%0d ref=%b exp=%0d/0", ref_pend, ref_cmd, MAXP); end
    rd_req = 1'b0;
    wr_req = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    i_ready = 1'b1;
    wr_req = 1'b1;
    n = 0;
    while (ref_pend !== 4'd3 && n < 200) begin
      step();
      n++;
    end
    checks++; if (wr_gnt !== 1'b1 || ref_pend !== 4'd3) begin failures++; $display("FAIL mid_setup gnt=%b pend=%0d exp=1/3", wr_gnt, ref_pend); end
    rst_n = 1'b0;
    #1;
    checks++; if (wr_gnt !== 1'b0) begin failures++; $display("FAIL mid_async_gnt got=%b exp=0", wr_gnt); end
    checks++; if (ref_pend !== 4'd0) begin failures++; $display("FAIL mid_async_pend got=%0d exp=0", ref_pend); end
    checks++; if (arb_busy !== 1'b1) begin failures++; $display("FAIL mid_async_busy got=%b exp=1", arb_busy); end
    step();
    rst_n = 1'b1;
    step();
    checks++; if (arb_busy !== 1'b0 || wr_gnt !== 1'b0) begin failures++; $display("FAIL mid_resume_idle busy=%b gnt=%b exp=0/0", arb_busy, wr_gnt); end
    step();
    checks++; if (wr_gnt !== 1'b1) begin failures++; $display("FAIL mid_resume_gnt got=%b exp=1", wr_gnt); end
    wr_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_off();
    test_rr();
    test_refresh();
    test_saturate();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ddr3_mcb_arb.md
DDR3_MCB_ARB -- requirements
Module: ddr3_mcb_arb

Interface
REQ-001 SHALL have parameter TREFI, default 6240, meaning refresh interval in ddr3_mcb_clk cycles.
REQ-002 SHALL have parameter TRFC, default 208, meaning refresh recovery wait in cycles after the REFRESH command.
REQ-003 SHALL have parameter MAX_PEND, default 8, meaning the maximum number of postponed refreshes.
REQ-004 ddr3_mcb_clk  input  1  clock; all state updates on the rising edge.
REQ-005 ddr3_mcb_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 i_ready  input  1  initialization complete, level.
REQ-007 rd_req  input  1  read requester wants the command bus, level.
REQ-008 wr_req  input  1  write requester wants the command bus, level.
REQ-009 cmd_done  input  1  one-cycle pulse: the granted transaction has finished.
REQ-010 rd_gnt  output  1  read owns the command bus.
REQ-011 wr_gnt  output  1  write owns the command bus.
REQ-012 ref_cmd  output  1  one-cycle pulse: issue REFRESH now.
REQ-013 arb_busy  output  1  state is not ARB_IDLE.
REQ-014 ref_pend  output  4  count of owed refreshes.

Function
REQ-015 The FSM SHALL have the states ARB_OFF, ARB_IDLE, ARB_RD, ARB_WR, ARB_REF and ARB_REFW; all outputs SHALL be registered.
REQ-016 ARB_OFF SHALL move to ARB_IDLE on the first cycle i_ready=1; while in ARB_OFF there SHALL be no grants, and the tREFI counter and ref_pend SHALL be held at their reset values.
REQ-017 The tREFI counter SHALL load TREFI on leaving ARB_OFF and decrement every cycle after that; when it reaches 1 it SHALL reload TREFI and increment ref_pend, saturating at MAX_PEND.
REQ-018 From ARB_IDLE, the priority SHALL be:
 - ref_pend==MAX_PEND -> ARB_REF;
 - else any rd_req/wr_req -> round-robin grant;
 - else ref_pend>0 -> ARB_REF;
 - else stay in ARB_IDLE.
REQ-019 Round-robin SHALL work as follows:
 - a one-bit last pointer updates on each grant;
 - when both requests are active, grant the requester not served last;
 - after reset the pointer favours rd.
REQ-020 rd_gnt=1 exactly while in ARB_RD, and wr_gnt=1 exactly while in ARB_WR; a grant SHALL assert on the cycle after the ARB_IDLE decision.
REQ-021 ARB_RD and ARB_WR SHALL return to ARB_IDLE on the cycle after cmd_done=1; requests SHALL NOT be preempted mid-grant, even at ref_pend==MAX_PEND.
REQ-022 cmd_done outside ARB_RD/ARB_WR SHALL be ignored.
REQ-023 ARB_REF SHALL last one cycle with ref_cmd=1, decrement ref_pend, load the wait counter with TRFC, and go to ARB_REFW.
REQ-024 ARB_REFW SHALL decrement the wait counter and return to ARB_IDLE when it reaches 1; ref_cmd=0 and no grants in ARB_REFW.
REQ-025 A tREFI tick in the same cycle as the ARB_REF decrement SHALL leave ref_pend unchanged.
REQ-026 A saturated increment with no decrement SHALL leave ref_pend at MAX_PEND and SHALL NOT wrap.
REQ-027 i_ready falling SHALL NOT abort a grant or refresh; i_ready is sampled only in ARB_OFF.
REQ-028 arb_busy SHALL equal (state != ARB_IDLE); it SHALL be 1 in ARB_OFF.

Reset
REQ-029 While ddr3_mcb_rst_n=0, the block SHALL be in ARB_OFF with rd_gnt=0, wr_gnt=0, ref_cmd=0, arb_busy=1, ref_pend=0, counters=0 and last pointer=wr, so that rd is favoured.
REQ-030 Reset assertion mid-grant or mid-refresh SHALL return the block to ARB_OFF immediately, asynchronously.
REQ-031 Operation SHALL resume one cycle after deassertion once i_ready=1.

Verification
REQ-032 i_ready=0, rd_req=1 for 100 cycles -> rd_gnt stays 0 and ref_pend stays 0; raise i_ready -> rd_gnt=1 two cycles later.
REQ-033 rd_req=wr_req=1 held, cmd_done pulsed on every grant -> grants alternate rd, wr, rd, wr.
REQ-034 Idle bus with TREFI=16, TRFC=4 -> ref_cmd pulse roughly 16 cycles after ready, ARB_REFW for 4 cycles, ref_pend returns to 0.
REQ-035 Continuous requests with TREFI=16 -> ref_pend climbs to 8 and then saturates; the next ARB_IDLE visit enters ARB_REF ahead of the requests; the refresh tick and ref_cmd in the same cycle keep ref_pend=8.
REQ-036 Assert reset during ARB_WR with ref_pend=3 -> wr_gnt=0 and ref_pend=0 at once; after release with i_ready=1 -> ARB_IDLE.
